// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
// Sequential radix-4 Booth multiplier. Retires two multiplier bits per cycle
// into a 2*WIDTH+4 bit accumulator; the same N = WIDTH/2+1 iterations cover
// both signed and unsigned operands because both are widened by two bits first.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   Start        request a multiply (accepted in IDLE or DONE only)
//   Signed_Mode  1 = two's-complement operands, 0 = unsigned (sampled with Start)
//   A, B         multiplicand / multiplier (sampled on the accepting edge)
//   Busy         high while an operation is in progress
//   Done         one-cycle pulse when Out has just been updated
//   Out          2*WIDTH product, held until the next completion
module booth_radix4_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Out
);

    localparam int unsigned N     = WIDTH / 2 + 1;
    localparam int unsigned EXT_W = WIDTH + 2;
    localparam int unsigned ACC_W = 2 * WIDTH + 4;
    localparam int unsigned BSH_W = EXT_W + 1;
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_a_sh;   // multiplicand pre-shifted by 2i for iteration i
    logic [BSH_W-1:0]    r_b_sh;   // {B_ext, b[-1]} shifted right 2 per iteration
    logic [CNT_W-1:0]    r_cnt;

    logic [EXT_W-1:0]    w_a_ext;
    logic [EXT_W-1:0]    w_b_ext;
    logic [ACC_W-1:0]    w_a_init;
    logic [2:0]          w_triplet;
    logic [ACC_W-1:0]    w_pp;
    logic [ACC_W-1:0]    w_acc_next;

    // Two-bit widening makes unsigned operands look like positive signed values
    assign w_a_ext  = Signed_Mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    assign w_b_ext  = Signed_Mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
    assign w_a_init = {{(ACC_W-EXT_W){w_a_ext[EXT_W-1]}}, w_a_ext};

    assign w_triplet = r_b_sh[2:0];

    // Booth digit selection: 0, +1, +1, +2, -2, -1, -1, 0
    always_comb begin
        w_pp = '0;
        case (w_triplet)
            3'b001, 3'b010: w_pp = r_a_sh;
            3'b011:         w_pp = r_a_sh << 1;
            3'b100:         w_pp = ~(r_a_sh << 1) + ACC_W'(1);
            3'b101, 3'b110: w_pp = ~r_a_sh + ACC_W'(1);
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_next = r_acc + w_pp;

    // Control FSM and datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_cnt   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Out     <= '0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state <= S_RUN;
                        Busy    <= 1'b1;
                        r_a_sh  <= w_a_init;
                        r_b_sh  <= {w_b_ext, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        Busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << 2;
                    r_b_sh <= r_b_sh >> 2;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Out     <= w_acc_next[2*WIDTH-1:0];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
